// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MIPS load/store bridge.
//   op_e     : CPU memory operation codes. Bits [1:0] give the access size
//              (0 byte, 1 half, 3 word), bit 2 marks zero-extension, and
//              bit 3 marks a store.
//   state_e  : bridge FSM states.
//   LANES_*  : byte-enable masks.
//   op_legal : defined op with a naturally aligned address.
//   lane_mask: active byte lanes for an access size at a byte offset.
package mips_lsu_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LH  = 4'd1,
    OP_LW  = 4'd3,
    OP_LBU = 4'd4,
    OP_LHU = 4'd5,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_CAP,
    WR,
    RMW_RD,
    RMW_MRG,
    RMW_WR
  } state_e;

  localparam logic [3:0] LANES_NONE = 4'b0000;
  localparam logic [3:0] LANES_ALL  = 4'b1111;
  localparam logic [3:0] LANES_LO_H = 4'b0011;
  localparam logic [3:0] LANES_HI_H = 4'b1100;
  localparam logic [3:0] LANE_B0    = 4'b0001;

  function automatic logic op_legal(input logic [3:0] op, input logic [1:0] lane);
    logic ok;
    case (op)
      OP_LB, OP_LBU, OP_SB: ok = 1'b1;
      OP_LH, OP_LHU, OP_SH: ok = ~lane[0];
      OP_LW, OP_SW:         ok = (lane == 2'b00);
      default:              ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      2'b00:   m = LANE_B0 << lane;
      2'b01:   m = lane[1] ? LANES_HI_H : LANES_LO_H;
      default: m = LANES_ALL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mips_lane_align.sv
// Combinational lane steering for the load/store bridge.
//   op         : latched operation code
//   lane       : byte offset within the word (addr[1:0])
//   word       : word read from RAM
//   wdata      : right-aligned store data from the CPU
//   load_data  : selected byte/half/word, sign- or zero-extended
//   store_data : word with the store lanes replaced (other lanes from word)
module mips_lane_align
  import mips_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] rep;
  logic [3:0]  m;
  logic [31:0] bit_mask;

  always_comb begin
    sel_b      = '0;
    sel_h      = '0;
    rep        = '0;
    m          = '0;
    bit_mask   = '0;
    load_data  = '0;
    store_data = '0;

    case (lane)
      2'd0:    sel_b = word[7:0];
      2'd1:    sel_b = word[15:8];
      2'd2:    sel_b = word[23:16];
      default: sel_b = word[31:24];
    endcase
    sel_h = lane[1] ? word[31:16] : word[15:0];

    case (op[1:0])
      2'b00:   load_data = op[2] ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
      2'b01:   load_data = op[2] ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
      default: load_data = word;
    endcase

    // Store data is replicated across all lanes so any selected lane
    // already holds the right bits; the mask picks which ones survive.
    case (op[1:0])
      2'b00:   rep = {4{wdata[7:0]}};
      2'b01:   rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    m        = lane_mask(op[1:0], lane);
    bit_mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    store_data = op[3] ? ((rep & bit_mask) | (word & ~bit_mask)) : word;
  end

endmodule

// File: rtl/mips_lsu_bridge.sv
// Load/store bridge between the MIPS datapath and a word-organised data RAM
// with a one-cycle registered read.
//   clk, reset          : clock (rising edge), async active-high reset
//   cpu_req/op/addr/wdata : request, accepted when cpu_req & cpu_ready
//   cpu_ready           : idle, can accept
//   cpu_rvalid/cpu_rdata: one-cycle load result pulse
//   cpu_err             : one-cycle pulse for misaligned/illegal op
//   mem_*               : RAM word bus (all outputs registered)
module mips_lsu_bridge
  import mips_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter logic [31:0] WORD_ADDR_MASK = 32'h0000_0FFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_op,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic [31:0]       mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_write,
  output logic              mem_read,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata
);

  state_e      state;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] load_data;
  logic [31:0] store_data;

  mips_lane_align u_align (
    .op         (op_q),
    .lane       (lane_q),
    .word       (mem_readdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      op_q           <= '0;
      lane_q         <= '0;
      wdata_q        <= '0;
      cpu_ready      <= 1'b1;
      cpu_rvalid     <= 1'b0;
      cpu_rdata      <= '0;
      cpu_err        <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= LANES_NONE;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      mem_writedata  <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      cpu_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (!op_legal(cpu_op, cpu_addr[1:0])) begin
              cpu_err <= 1'b1;
            end else begin
              op_q           <= cpu_op;
              lane_q         <= cpu_addr[1:0];
              wdata_q        <= cpu_wdata;
              mem_address    <= 32'(cpu_addr[ADDR_W-1:2]) & WORD_ADDR_MASK;
              mem_byteenable <= lane_mask(cpu_op[1:0], cpu_addr[1:0]);
              cpu_ready      <= 1'b0;
              if (cpu_op == OP_SW) begin
                state         <= WR;
                mem_write     <= 1'b1;
                mem_writedata <= cpu_wdata;
              end else if (cpu_op[3]) begin
                state    <= RMW_RD;
                mem_read <= 1'b1;
              end else begin
                state    <= RD;
                mem_read <= 1'b1;
              end
            end
          end
        end
        RD: begin
          mem_read <= 1'b0;
          state    <= RD_CAP;
        end
        RD_CAP: begin
          cpu_rdata      <= load_data;
          cpu_rvalid     <= 1'b1;
          cpu_ready      <= 1'b1;
          mem_byteenable <= LANES_NONE;
          state          <= IDLE;
        end
        WR: begin
          mem_write      <= 1'b0;
          mem_byteenable <= LANES_NONE;
          cpu_ready      <= 1'b1;
          state          <= IDLE;
        end
        RMW_RD: begin
          mem_read <= 1'b0;
          state    <= RMW_MRG;
        end
        RMW_MRG: begin
          mem_writedata <= store_data;
          mem_write     <= 1'b1;
          state         <= RMW_WR;
        end
        RMW_WR: begin
          mem_write      <= 1'b0;
          mem_byteenable <= LANES_NONE;
          cpu_ready      <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          mem_read       <= 1'b0;
          mem_write      <= 1'b0;
          mem_byteenable <= LANES_NONE;
          cpu_ready      <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
